// File: rtl/seg_decimal_scroller.sv
// seg_decimal_scroller: converts a 6-bit ALU result (natural or two's complement)
// to decimal by repeated subtraction, then cycles its digits on one 7-segment
// display with a blank gap between loops. dp marks a negative value; an error
// result shows the "E" glyph instead.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | nothing accepted since reset, display blank
// CONVERT | subtracting 10 per cycle from mag into tens, input stalled
// TENS    | showing the tens digit (only entered when tens != 0)
// UNITS   | showing the units digit
// ERR     | showing the error glyph
// GAP     | blank display between loops
module seg_decimal_scroller #(
  parameter int NBITS_IN     = 6,
  parameter int NBITS_SEG    = 8,
  parameter int DWELL_CYCLES = 2,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                 clk_2,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NBITS_IN-1:0]  in_value,
  input  logic                 in_signed,
  input  logic                 in_error,
  output logic [NBITS_SEG-1:0] seg,
  output logic                 busy,
  output logic                 done
);

  localparam int TENS_W  = $clog2((2 ** NBITS_IN) / 10 + 1);
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    TENS    = 3'd2,
    UNITS   = 3'd3,
    ERR     = 3'd4,
    GAP     = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic [NBITS_IN-1:0]  mag;
  logic [TENS_W-1:0]    tens;
  logic                 neg;
  logic                 err;
  logic [CNT_W-1:0]     dwell_cnt;
  logic [NBITS_SEG-1:0] seg_nxt;
  logic                 accept;
  logic                 dwell_tc;
  logic                 blank_tc;
  logic                 in_neg;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  assign accept   = in_valid && in_ready;
  assign in_neg   = in_signed & in_value[NBITS_IN-1];
  assign dwell_tc = (dwell_cnt == CNT_W'(DWELL_CYCLES - 1));
  assign blank_tc = (dwell_cnt == CNT_W'(BLANK_CYCLES - 1));

  // State register
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; an accept in any ready state overrides the dwell timer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = in_error ? ERR : CONVERT;
      end
      CONVERT: begin
        if (mag < NBITS_IN'(10)) state_nxt = (tens != '0) ? TENS : UNITS;
      end
      TENS: begin
        if (accept)        state_nxt = in_error ? ERR : CONVERT;
        else if (dwell_tc) state_nxt = UNITS;
      end
      UNITS: begin
        if (accept)        state_nxt = in_error ? ERR : CONVERT;
        else if (dwell_tc) state_nxt = GAP;
      end
      ERR: begin
        if (accept)        state_nxt = in_error ? ERR : CONVERT;
        else if (dwell_tc) state_nxt = GAP;
      end
      GAP: begin
        if (accept)        state_nxt = in_error ? ERR : CONVERT;
        else if (blank_tc) state_nxt = err ? ERR : ((tens != '0) ? TENS : UNITS);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the current state; seg_nxt is what the display shows one cycle later
  always_comb begin
    in_ready = (state != CONVERT);
    busy     = (state != IDLE);
    done     = (state == CONVERT) && (mag < NBITS_IN'(10));
    seg_nxt  = '0;
    case (state)
      TENS: begin
        seg_nxt[6:0]           = glyph(4'(tens));
        seg_nxt[NBITS_SEG-1]   = neg;
      end
      UNITS: begin
        seg_nxt[6:0]           = glyph(4'(mag));
        seg_nxt[NBITS_SEG-1]   = neg;
      end
      ERR:     seg_nxt[6:0]    = 7'h79;
      default: seg_nxt         = '0;
    endcase
  end

  // Display register; blanks immediately on a new accept
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n)    seg <= '0;
    else if (accept) seg <= '0;
    else             seg <= seg_nxt;
  end

  // Operand capture and the subtract-by-ten conversion
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      mag  <= '0;
      tens <= '0;
      neg  <= 1'b0;
      err  <= 1'b0;
    end else if (accept) begin
      neg  <= in_neg;
      mag  <= in_neg ? (NBITS_IN'(0) - in_value) : in_value;
      tens <= '0;
      err  <= in_error;
    end else if (state == CONVERT && mag >= NBITS_IN'(10)) begin
      mag  <= mag - NBITS_IN'(10);
      tens <= tens + 1'b1;
    end
  end

  // Dwell timer: restarts on every state change or accept, saturates otherwise
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n)                           dwell_cnt <= '0;
    else if (accept || state_nxt != state)  dwell_cnt <= '0;
    else if (dwell_cnt != CNT_W'(CNT_MAX))  dwell_cnt <= dwell_cnt + 1'b1;
  end

endmodule
